// File: rtl/mult_ctrl_pkg.sv
// Shared types and helpers for the shift-add multiplier sequencing controller.
package mult_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } state_e;

  // Width needed to count 0..width steps inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/tick_div.sv
// Free-running enable divider: one-cycle tick when the count reaches DIV-1, then wraps.
module tick_div #(
  parameter int unsigned DIV = 2
) (
  input  logic clk100MHz,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick = en & (cnt_q == LAST);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for an iterative shift-add multiplier: one step per slow tick or per clock,
// plus a free-running display scan enable.
module mult_seq_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned STEP_DIV = 400000000,
  parameter int unsigned SCAN_DIV = 20000
) (
  input  logic                          clk100MHz,
  input  logic                          rst,
  input  logic                          go,
  input  logic                          fast,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  output logic                          busy,
  output logic                          done,
  output logic [2*WIDTH-1:0]            product,
  output logic [cnt_width(WIDTH)-1:0]   step_cnt,
  output logic [1:0]                    state,
  output logic                          scan_tick
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e              state_q, state_d;
  logic                go_q;
  logic                start;
  logic                step_tick;
  logic                step_en;
  logic [2*WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]    mplier_q;
  logic [2*WIDTH-1:0]  product_q;
  logic [CNT_W-1:0]    step_cnt_q;
  logic                busy_q, done_q;

  assign start   = go & ~go_q;
  assign step_en = fast | step_tick;

  tick_div #(
    .DIV (STEP_DIV)
  ) u_step_div (
    .clk100MHz (clk100MHz),
    .rst       (rst),
    .clr       (state_q == StLoad),
    .en        (state_q == StRun),
    .tick      (step_tick)
  );

  tick_div #(
    .DIV (SCAN_DIV)
  ) u_scan_div (
    .clk100MHz (clk100MHz),
    .rst       (rst),
    .clr       (1'b0),
    .en        (1'b1),
    .tick      (scan_tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StLoad;
      StLoad: state_d = StRun;
      StRun:  if (step_en && step_cnt_q == CNT_W'(WIDTH - 1)) state_d = StDone;
      StDone: if (start) state_d = StLoad;
      default: state_d = StIdle;
    endcase
  end

  // go_q resets high so a go held through reset is not seen as a rising edge.
  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      go_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go;
      busy_q  <= (state_d == StLoad) || (state_d == StRun);
      done_q  <= (state_d == StDone);
    end
  end

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      mcand_q    <= '0;
      mplier_q   <= '0;
      product_q  <= '0;
      step_cnt_q <= '0;
    end else if (state_q == StLoad) begin
      mcand_q    <= {{WIDTH{1'b0}}, a};
      mplier_q   <= b;
      product_q  <= '0;
      step_cnt_q <= '0;
    end else if (state_q == StRun && step_en) begin
      if (mplier_q[0]) product_q <= product_q + mcand_q;
      mcand_q    <= mcand_q << 1;
      mplier_q   <= mplier_q >> 1;
      step_cnt_q <= step_cnt_q + CNT_W'(1);
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign product  = product_q;
  assign step_cnt = step_cnt_q;
  assign state    = state_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed self-checking bench for mult_seq_ctrl (WIDTH=4, STEP_DIV=10, SCAN_DIV=8).
module tb_mult_seq_ctrl;

  logic       clk100MHz = 1'b0;
  logic       rst = 1'b0;
  logic       go = 1'b1;
  logic       fast = 1'b1;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       busy, done, scan_tick;
  logic [7:0] product;
  logic [2:0] step_cnt;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;
  bit scan_on = 1'b0;
  int scan_k = 0;

  mult_seq_ctrl #(
    .WIDTH    (4),
    .STEP_DIV (10),
    .SCAN_DIV (8)
  ) dut (
    .clk100MHz (clk100MHz),
    .rst       (rst),
    .go        (go),
    .fast      (fast),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .step_cnt  (step_cnt),
    .state     (state),
    .scan_tick (scan_tick)
  );

  always #5 clk100MHz = ~clk100MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk100MHz);
    #1;
  endtask

  // Leaves time just after the edge where start is sampled (state should be LOAD).
  task automatic pulse_go();
    go = 1'b0;
    step();
    go = 1'b1;
    step();
  endtask

  // scan_tick is high exactly when 8k+7 edges have passed since reset release.
  always @(posedge clk100MHz) begin
    if (scan_on) begin
      #1;
      scan_k++;
      check("scan_tick", {31'd0, scan_tick}, {31'd0, (scan_k % 8) == 7});
    end
  end

  initial begin
    int cyc;
    int busy_cyc;

    // Reset with go held high.
    repeat (3) step();
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    check("rst_step_cnt", step_cnt, 0);
    check("rst_scan", scan_tick, 0);
    rst = 1'b1;
    scan_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("hold_idle", state, 0);
    end
    check("idle_busy", busy, 0);

    // Fast: 3*5 = 15, DONE 5 edges after start edge, busy for 5 cycles.
    a = 4'd3;
    b = 4'd5;
    pulse_go();
    check("load_state", state, 1);
    busy_cyc = 0;
    cyc = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cyc++;
      if (cyc == 2) begin
        a = 4'd7;
        b = 4'd2;
      end
      step();
      cyc++;
    end
    check("fast_latency", cyc, 5);
    check("fast_busy_cyc", busy_cyc, 5);
    check("fast_product", product, 15);
    check("fast_step_cnt", step_cnt, 4);
    check("fast_state", state, 3);
    check("fast_busy_off", busy, 0);
    repeat (3) step();
    check("done_hold", product, 15);

    // Restart from DONE: 15*15 = 225.
    a = 4'd15;
    b = 4'd15;
    pulse_go();
    cyc = 0;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
    check("max_latency", cyc, 5);
    check("max_product", product, 225);

    // 0*9 = 0 after 4 steps.
    a = 4'd0;
    b = 4'd9;
    pulse_go();
    cyc = 0;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
    check("zero_product", product, 0);
    check("zero_step_cnt", step_cnt, 4);

    // Slow: 9*13 = 117; b=1101 steps add 9, +0, +36, +72 at RUN edges 10,20,30,40.
    fast = 1'b0;
    a = 4'd9;
    b = 4'd13;
    pulse_go();
    step();
    check("slow_run", state, 2);
    for (int k = 1; k <= 40; k++) begin
      if (k == 14) go = 1'b0;
      if (k == 15) go = 1'b1;
      step();
      if (k == 9)  check("slow_k9", product, 0);
      if (k == 10) check("slow_k10", product, 9);
      if (k == 10) check("slow_cnt_k10", step_cnt, 1);
      if (k == 18) check("slow_go_ignored", state, 2);
      if (k == 29) check("slow_k29", product, 9);
      if (k == 30) check("slow_k30", product, 45);
      if (k == 39) check("slow_k39_state", state, 2);
    end
    check("slow_done", done, 1);
    check("slow_product", product, 117);
    check("slow_step_cnt", step_cnt, 4);

    // Asynchronous reset mid-RUN.
    fast = 1'b1;
    a = 4'd15;
    b = 4'd15;
    pulse_go();
    step();
    step();
    check("mid_run_state", state, 2);
    check("mid_run_product", product, 15);
    #2;
    scan_on = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_product", product, 0);
    check("arst_busy", busy, 0);
    #2;
    rst = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
